// File: rtl/lcd_pixel_writer.sv
// lcd_pixel_writer: programs a window on a 16-bit 8080-style LCD panel
// (0x2A/0x2B/0x2C) and streams one RGB565 word per color_ok strobe.
// Ports:
//   pclk, rst                  clock, async active-high reset
//   win_req, win_x/y/w/h       window request and geometry
//   color_ok, color_data       upstream pixel strobe and colour
//   write_ok, frame_done       pacing pulse, window-complete pulse
//   busy, protocol_err         transfer active, sticky misuse flag
//   lcd_cs/rs/wr/rd, lcd_data  panel bus (cs/wr/rd active-low)
module lcd_pixel_writer #(
    parameter int WR_LOW  = 2,
    parameter int WR_HIGH = 2
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        win_req,
    input  logic [15:0] win_x,
    input  logic [15:0] win_y,
    input  logic [15:0] win_w,
    input  logic [15:0] win_h,
    input  logic        color_ok,
    input  logic [15:0] color_data,
    output logic        write_ok,
    output logic        frame_done,
    output logic        busy,
    output logic        protocol_err,
    output logic        lcd_cs,
    output logic        lcd_rs,
    output logic        lcd_wr,
    output logic        lcd_rd,
    output logic [15:0] lcd_data
);

    localparam int T  = WR_LOW + WR_HIGH;
    localparam int PW = $clog2(T + 1);
    localparam logic [PW-1:0] PH_LAST = PW'(T - 1);
    localparam logic [PW-1:0] PH_LOW  = PW'(WR_LOW);
    localparam logic [PW-1:0] PH_ONE  = PW'(1);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] SETUP    = 3'd1;
    localparam logic [2:0] ARM      = 3'd2;
    localparam logic [2:0] WAIT_PIX = 3'd3;
    localparam logic [2:0] PIX_WR   = 3'd4;
    localparam logic [2:0] DONE     = 3'd5;

    logic [2:0]    state_q, state_d;
    logic [3:0]    widx_q, widx_d;
    logic [PW-1:0] ph_q, ph_d;
    logic [15:0]   x0_q, x0_d, y0_q, y0_d;
    logic [15:0]   x1_q, x1_d, y1_q, y1_d;
    logic [31:0]   total_q, total_d;
    logic [31:0]   cnt_q, cnt_d;
    logic          cs_q, cs_d, rs_q, rs_d, wr_q, wr_d;
    logic [15:0]   data_q, data_d;
    logic          wok_q, wok_d, fd_q, fd_d;
    logic          busy_q, busy_d, err_q, err_d;

    logic [3:0]  nxt_idx;
    logic [16:0] nxt_word;
    logic        accept;

    // {rs, data} of the setup word following the current one
    always_comb begin
        nxt_idx = widx_q + 4'd1;
        case (nxt_idx)
            4'd1:    nxt_word = {1'b1, 8'h00, x0_q[15:8]};
            4'd2:    nxt_word = {1'b1, 8'h00, x0_q[7:0]};
            4'd3:    nxt_word = {1'b1, 8'h00, x1_q[15:8]};
            4'd4:    nxt_word = {1'b1, 8'h00, x1_q[7:0]};
            4'd5:    nxt_word = {1'b0, 16'h002B};
            4'd6:    nxt_word = {1'b1, 8'h00, y0_q[15:8]};
            4'd7:    nxt_word = {1'b1, 8'h00, y0_q[7:0]};
            4'd8:    nxt_word = {1'b1, 8'h00, y1_q[15:8]};
            4'd9:    nxt_word = {1'b1, 8'h00, y1_q[7:0]};
            default: nxt_word = {1'b0, 16'h002C};
        endcase
    end

    always_comb begin
        state_d = state_q;
        widx_d  = widx_q;
        ph_d    = ph_q;
        x0_d    = x0_q;
        y0_d    = y0_q;
        x1_d    = x1_q;
        y1_d    = y1_q;
        total_d = total_q;
        cnt_d   = cnt_q;
        cs_d    = cs_q;
        rs_d    = rs_q;
        wr_d    = wr_q;
        data_d  = data_q;
        wok_d   = 1'b0;
        fd_d    = 1'b0;
        busy_d  = busy_q;
        // ARM shares its cycle with the first write_ok, so it accepts too
        accept  = color_ok && (state_q == ARM || state_q == WAIT_PIX);
        err_d   = err_q | (color_ok & ~accept);

        case (state_q)
            IDLE: begin
                if (win_req) begin
                    if (win_w == 16'd0 || win_h == 16'd0) begin
                        fd_d = 1'b1;
                    end else begin
                        x0_d    = win_x;
                        y0_d    = win_y;
                        x1_d    = win_x + win_w - 16'd1;
                        y1_d    = win_y + win_h - 16'd1;
                        total_d = {16'd0, win_w} * {16'd0, win_h};
                        cnt_d   = 32'd0;
                        widx_d  = 4'd0;
                        ph_d    = '0;
                        busy_d  = 1'b1;
                        cs_d    = 1'b0;
                        rs_d    = 1'b0;
                        data_d  = 16'h002A;
                        wr_d    = 1'b0;
                        state_d = SETUP;
                    end
                end
            end
            SETUP, PIX_WR: begin
                if (ph_q != PH_LAST) begin
                    ph_d = ph_q + PH_ONE;
                    wr_d = (ph_q + PH_ONE) >= PH_LOW;
                end else if (state_q == SETUP) begin
                    if (widx_q == 4'd10) begin
                        wok_d   = 1'b1;
                        state_d = ARM;
                    end else begin
                        widx_d         = nxt_idx;
                        ph_d           = '0;
                        {rs_d, data_d} = nxt_word;
                        wr_d           = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + 32'd1;
                    wok_d = 1'b1;
                    if (cnt_q + 32'd1 == total_q) begin
                        fd_d    = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = WAIT_PIX;
                    end
                end
            end
            ARM, WAIT_PIX: begin
                if (accept) begin
                    ph_d    = '0;
                    rs_d    = 1'b1;
                    data_d  = color_data;
                    wr_d    = 1'b0;
                    state_d = PIX_WR;
                end else begin
                    state_d = WAIT_PIX;
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                cs_d    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            widx_q  <= 4'd0;
            ph_q    <= '0;
            x0_q    <= 16'd0;
            y0_q    <= 16'd0;
            x1_q    <= 16'd0;
            y1_q    <= 16'd0;
            total_q <= 32'd0;
            cnt_q   <= 32'd0;
            cs_q    <= 1'b1;
            rs_q    <= 1'b1;
            wr_q    <= 1'b1;
            data_q  <= 16'd0;
            wok_q   <= 1'b0;
            fd_q    <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            widx_q  <= widx_d;
            ph_q    <= ph_d;
            x0_q    <= x0_d;
            y0_q    <= y0_d;
            x1_q    <= x1_d;
            y1_q    <= y1_d;
            total_q <= total_d;
            cnt_q   <= cnt_d;
            cs_q    <= cs_d;
            rs_q    <= rs_d;
            wr_q    <= wr_d;
            data_q  <= data_d;
            wok_q   <= wok_d;
            fd_q    <= fd_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    assign write_ok     = wok_q;
    assign frame_done   = fd_q;
    assign busy         = busy_q;
    assign protocol_err = err_q;
    assign lcd_cs       = cs_q;
    assign lcd_rs       = rs_q;
    assign lcd_wr       = wr_q;
    assign lcd_rd       = 1'b1;
    assign lcd_data     = data_q;

endmodule

// File: tb/tb_lcd_pixel_writer.sv
// Self-checking bench for lcd_pixel_writer: window table, random windows,
// reset mid-pixel and a WR_LOW=1/WR_HIGH=3 instance.
module tb_lcd_pixel_writer;

    localparam int T = 4;

    logic        pclk, rst;
    logic        win_req, color_ok;
    logic [15:0] win_x, win_y, win_w, win_h, color_data;
    logic        write_ok, frame_done, busy, protocol_err;
    logic        lcd_cs, lcd_rs, lcd_wr, lcd_rd;
    logic [15:0] lcd_data;

    logic        b_win_req, b_color_ok;
    logic [15:0] b_win_x, b_win_y, b_win_w, b_win_h, b_color_data;
    logic        b_write_ok, b_frame_done, b_busy, b_protocol_err;
    logic        b_lcd_cs, b_lcd_rs, b_lcd_wr, b_lcd_rd;
    logic [15:0] b_lcd_data;

    lcd_pixel_writer dut (
        .pclk(pclk), .rst(rst), .win_req(win_req),
        .win_x(win_x), .win_y(win_y), .win_w(win_w), .win_h(win_h),
        .color_ok(color_ok), .color_data(color_data),
        .write_ok(write_ok), .frame_done(frame_done), .busy(busy),
        .protocol_err(protocol_err), .lcd_cs(lcd_cs), .lcd_rs(lcd_rs),
        .lcd_wr(lcd_wr), .lcd_rd(lcd_rd), .lcd_data(lcd_data)
    );

    lcd_pixel_writer #(.WR_LOW(1), .WR_HIGH(3)) dut2 (
        .pclk(pclk), .rst(rst), .win_req(b_win_req),
        .win_x(b_win_x), .win_y(b_win_y), .win_w(b_win_w), .win_h(b_win_h),
        .color_ok(b_color_ok), .color_data(b_color_data),
        .write_ok(b_write_ok), .frame_done(b_frame_done), .busy(b_busy),
        .protocol_err(b_protocol_err), .lcd_cs(b_lcd_cs), .lcd_rs(b_lcd_rs),
        .lcd_wr(b_lcd_wr), .lcd_rd(b_lcd_rd), .lcd_data(b_lcd_data)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    int tests = 0;
    int fails = 0;
    bit exp_err = 1'b0;

    typedef struct {
        logic [15:0] x, y, w, h, x1, y1;
        int mode;
        bit stray;
        bit reqbusy;
    } vec_t;

    vec_t tbl[6];

    task automatic check(input string nm, input longint act, input longint exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge pclk);
        #1;
    endtask

    // mode 0: answer write_ok in the same cycle with 0000/FFFF pattern
    // mode 1: random answer delay, random colours
    task automatic run_frame(input logic [15:0] x, y, w, h, x1, y1,
                             input int mode, input bit stray,
                             input bit reqbusy, input string tag);
        logic [16:0] q[$];
        logic [16:0] got, prevw;
        logic [15:0] c;
        logic [1:0]  b1;
        longint npix, exp_fdk;
        int k, wok, fd, fdk, lastwok, firstwok, sent;
        int bad, werr, perr, lowlen, highlen, straynxt, limit, cslow;
        bit pending, prev_wr, done_ok, tmo;
        npix = longint'(w) * longint'(h);
        if (npix != 0) begin
            q.push_back({1'b0, 16'h002A});
            q.push_back({1'b1, 8'h00, x[15:8]});
            q.push_back({1'b1, 8'h00, x[7:0]});
            q.push_back({1'b1, 8'h00, x1[15:8]});
            q.push_back({1'b1, 8'h00, x1[7:0]});
            q.push_back({1'b0, 16'h002B});
            q.push_back({1'b1, 8'h00, y[15:8]});
            q.push_back({1'b1, 8'h00, y[7:0]});
            q.push_back({1'b1, 8'h00, y1[15:8]});
            q.push_back({1'b1, 8'h00, y1[7:0]});
            q.push_back({1'b0, 16'h002C});
        end
        wok = 0; fd = 0; fdk = -1; lastwok = -1; firstwok = -1;
        sent = 0; bad = 0; werr = 0; perr = 0; lowlen = 0;
        highlen = 100; straynxt = -1; cslow = 0; b1 = 2'b00;
        pending = 0; prev_wr = 1; done_ok = 0; tmo = 0; prevw = '0;
        limit = 200 + int'(npix) * 24;
        win_x = x; win_y = y; win_w = w; win_h = h;
        win_req = 1'b1; color_ok = 1'b0;
        tick();
        k = 1;
        while (1) begin
            win_req = 1'b0;
            color_ok = 1'b0;
            if (k == 1) b1 = {busy, lcd_cs};
            if (!lcd_cs) cslow++;
            if (lcd_rd !== 1'b1) werr++;
            if (!lcd_wr) begin
                got = {lcd_rs, lcd_data};
                if (lcd_cs) werr++;
                if (prev_wr) begin
                    if (highlen < 2) werr++;
                    if (q.size() == 0) bad++;
                    else if (q.pop_front() !== got) bad++;
                    lowlen = 1;
                end else begin
                    lowlen++;
                    if (got !== prevw) werr++;
                end
                prevw = got;
            end else begin
                if (!prev_wr) begin
                    if (lowlen != 2) werr++;
                    highlen = 0;
                end
                highlen++;
            end
            prev_wr = lcd_wr;
            if (write_ok) begin
                wok++;
                if (firstwok < 0) firstwok = k;
                else if (k - lastwok != T + 1) perr++;
                lastwok = k;
                pending = 1;
            end
            if (frame_done) begin
                fd++;
                fdk = k;
            end
            if (fdk >= 0 && k == fdk + 1) begin
                done_ok = (busy == 1'b0 && lcd_cs == 1'b1);
                break;
            end
            if (k >= limit) begin
                tmo = 1;
                break;
            end
            if (pending && sent < npix) begin
                if (mode == 0 || $urandom_range(0, 2) == 0) begin
                    if (mode == 0) c = (sent % 2 != 0) ? 16'hFFFF : 16'h0000;
                    else c = 16'($urandom);
                    color_ok = 1'b1;
                    color_data = c;
                    q.push_back({1'b1, c});
                    pending = 0;
                    sent++;
                    if (stray && sent == 2) straynxt = k + 1;
                end
            end
            if (stray && (k == 10 || k == straynxt)) begin
                color_ok = 1'b1;
                color_data = 16'hDEAD;
            end
            if (reqbusy && (k == 5 || k == firstwok + 2)) begin
                win_req = 1'b1;
                win_x = 16'h1234; win_y = 16'h5678;
                win_w = 16'd9; win_h = 16'd9;
            end
            tick();
            k++;
        end
        if (npix == 0) exp_fdk = 1;
        else if (mode == 0) exp_fdk = 45 + npix * (T + 1);
        else exp_fdk = lastwok;
        check({tag, "_timeout"}, tmo, 0);
        check({tag, "_cycle1_busy_cs"}, b1, (npix != 0) ? 2 : 1);
        check({tag, "_first_wok"}, firstwok, (npix != 0) ? 45 : -1);
        check({tag, "_wok_count"}, wok, (npix != 0) ? npix + 1 : 0);
        check({tag, "_frame_done_count"}, fd, 1);
        check({tag, "_frame_done_cycle"}, fdk, exp_fdk);
        check({tag, "_bus_words_bad"}, bad + q.size(), 0);
        check({tag, "_wr_timing_errs"}, werr, 0);
        if (mode == 0) check({tag, "_pix_period_errs"}, perr, 0);
        check({tag, "_idle_after_done"}, done_ok, 1);
        if (npix == 0) check({tag, "_empty_cs_low"}, cslow, 0);
        if (stray) exp_err = 1'b1;
        check({tag, "_protocol_err"}, protocol_err, exp_err);
    endtask

    initial begin
        int n, k, first, lowv, hl, ll, wokn, fdn;
        bit prev, fdseen;
        logic [15:0] rx, ry, rw, rh;

        tbl[0] = '{16'd10, 16'd20, 16'd24, 16'd40, 16'h0021, 16'h003B,
                   0, 1'b0, 1'b0};
        tbl[1] = '{16'hFFF0, 16'd0, 16'h0020, 16'd1, 16'h000F, 16'h0000,
                   0, 1'b0, 1'b0};
        tbl[2] = '{16'd5, 16'd6, 16'd0, 16'd7, 16'h0000, 16'h0000,
                   0, 1'b0, 1'b0};
        tbl[3] = '{16'd100, 16'd200, 16'd3, 16'd4, 16'h0066, 16'h00CB,
                   1, 1'b1, 1'b1};
        tbl[4] = '{16'd7, 16'd9, 16'd2, 16'd1, 16'h0008, 16'h0009,
                   0, 1'b0, 1'b0};
        tbl[5] = '{16'd3, 16'd3, 16'd5, 16'd0, 16'h0000, 16'h0000,
                   0, 1'b0, 1'b0};

        rst = 1'b1;
        win_req = 0; color_ok = 0; color_data = 0;
        win_x = 0; win_y = 0; win_w = 0; win_h = 0;
        b_win_req = 0; b_color_ok = 0; b_color_data = 0;
        b_win_x = 0; b_win_y = 0; b_win_w = 0; b_win_h = 0;
        #2;
        check("rst_strobes", {lcd_cs, lcd_rs, lcd_wr, lcd_rd}, 4'b1111);
        check("rst_data", lcd_data, 0);
        check("rst_flags", {write_ok, frame_done, busy, protocol_err}, 0);
        check("rst2_strobes", {b_lcd_cs, b_lcd_wr, b_busy}, 3'b110);
        tick();
        tick();
        rst = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) begin
            run_frame(tbl[i].x, tbl[i].y, tbl[i].w, tbl[i].h,
                      tbl[i].x1, tbl[i].y1, tbl[i].mode,
                      tbl[i].stray, tbl[i].reqbusy, $sformatf("tbl%0d", i));
            tick();
        end

        // reset while a pixel word has lcd_wr low
        win_x = 16'd2; win_y = 16'd3; win_w = 16'd2; win_h = 16'd2;
        win_req = 1'b1;
        tick();
        win_req = 1'b0;
        n = 0;
        while (!write_ok && n < 100) begin
            tick();
            n++;
        end
        check("mid_first_wok_seen", write_ok, 1);
        color_ok = 1'b1;
        color_data = 16'hA5A5;
        tick();
        color_ok = 1'b0;
        check("mid_wr_low", {lcd_wr, lcd_cs, busy}, 3'b001);
        rst = 1'b1;
        #1;
        check("mid_rst_wr_cs", {lcd_wr, lcd_cs}, 2'b11);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_flags", {write_ok, frame_done, protocol_err}, 0);
        exp_err = 1'b0;
        tick();
        rst = 1'b0;
        fdn = 0;
        for (int i = 0; i < 10; i++) begin
            if (frame_done) fdn++;
            tick();
        end
        check("mid_rst_no_frame_done", fdn, 0);
        run_frame(16'd10, 16'd20, 16'd2, 16'd2, 16'h000B, 16'h0015,
                  0, 1'b0, 1'b0, "restart");
        tick();

        for (int i = 0; i < 4; i++) begin
            rx = 16'($urandom);
            ry = 16'($urandom);
            rw = 16'($urandom_range(1, 6));
            rh = 16'($urandom_range(1, 5));
            run_frame(rx, ry, rw, rh, rx + rw - 16'd1, ry + rh - 16'd1,
                      1, 1'b0, 1'b0, $sformatf("rnd%0d", i));
            tick();
        end

        // WR_LOW=1, WR_HIGH=3 instance
        b_win_x = 16'd1; b_win_y = 16'd1; b_win_w = 16'd2; b_win_h = 16'd1;
        b_win_req = 1'b1;
        tick();
        b_win_req = 1'b0;
        k = 1; first = -1; lowv = 0; prev = 1; hl = 100; ll = 0;
        fdseen = 0; wokn = 0;
        while (k < 400 && !fdseen) begin
            b_color_ok = 1'b0;
            if (!b_lcd_wr) begin
                if (prev) begin
                    if (hl < 3) lowv++;
                    ll = 1;
                end else begin
                    ll++;
                end
            end else begin
                if (!prev) begin
                    if (ll != 1) lowv++;
                    hl = 0;
                end
                hl++;
            end
            prev = b_lcd_wr;
            if (b_write_ok) begin
                wokn++;
                if (first < 0) first = k;
                if (!b_frame_done) begin
                    b_color_ok = 1'b1;
                    b_color_data = 16'h1234;
                end
            end
            if (b_frame_done) fdseen = 1;
            tick();
            k++;
        end
        b_color_ok = 1'b0;
        check("p13_first_wok", first, 45);
        check("p13_wr_pulse_errs", lowv, 0);
        check("p13_frame_done", fdseen, 1);
        check("p13_wok_count", wokn, 3);
        check("p13_protocol_err", b_protocol_err, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
